// File: rtl/memxfer_pkg.sv
// Shared FSM state codes and transform op-codes for the memory transfer engine.
package memxfer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] OP_PASS = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_SUB  = 2'd3;

endpackage

// File: rtl/memxfer_alu.sv
// Combinational word transform (pass/add/xor/sub); zero latency, no flow control.
// MEMXFER_SAT_EN makes add clamp at all-ones and sub clamp at zero instead of wrapping.
module memxfer_alu
    import memxfer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]        op_sel,
    input  logic [DATA_W-1:0] op_k,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] add_res;
    logic [DATA_W-1:0] sub_res;

`ifdef MEMXFER_SAT_EN
    logic [DATA_W:0] add_ext;
    logic [DATA_W:0] sub_ext;

    // The extra MSB is the carry for add and the borrow for sub.
    always_comb begin
        add_ext = {1'b0, din} + {1'b0, op_k};
        sub_ext = {1'b0, din} - {1'b0, op_k};
        add_res = add_ext[DATA_W] ? '1 : add_ext[DATA_W-1:0];
        sub_res = sub_ext[DATA_W] ? '0 : sub_ext[DATA_W-1:0];
    end
`else
    assign add_res = din + op_k;
    assign sub_res = din - op_k;
`endif

    always_comb begin
        dout = din;
        case (op_sel)
            OP_PASS: dout = din;
            OP_ADD:  dout = add_res;
            OP_XOR:  dout = din ^ op_k;
            OP_SUB:  dout = sub_res;
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/memxfer_engine.sv
// Block copy src RAM -> transform -> dst RAM; first write RD_LAT+2 cycles after start, done at len+RD_LAT+2.
// No backpressure: one read per cycle while running; MEMXFER_SAT_EN selects saturating add/sub.
module memxfer_engine
    import memxfer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   len,
    input  logic [1:0]        op_sel,
    input  logic [DATA_W-1:0] op_k,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   xfer_cnt
);

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] k_q, k_d;
    logic [ADDR_W:0]   rd_idx_q, rd_idx_d;
    logic [RD_LAT-1:0] vpipe_q, vpipe_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W:0]   xfer_q, xfer_d;

    logic              active;
    logic              rd_fire;
    logic              ret_vld;
    logic [DATA_W-1:0] alu_out;

    assign active  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign rd_fire = (state_q == ST_RUN);
    assign ret_vld = vpipe_q[RD_LAT-1];

    memxfer_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .op_sel(op_q),
        .op_k  (k_q),
        .din   (rd_data),
        .dout  (alu_out)
    );

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        op_d      = op_q;
        k_d       = k_q;
        rd_idx_d  = rd_idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        xfer_d    = xfer_q;

        vpipe_d[0] = rd_fire;
        for (int i = 1; i < RD_LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end

        // Returning word: the write index is simply the number of writes issued so far.
        if (ret_vld && active && !abort) begin
            wr_en_d   = 1'b1;
            wr_addr_d = dst_q + xfer_q[ADDR_W-1:0];
            wr_data_d = alu_out;
            xfer_d    = xfer_q + CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d    = src_base;
                    dst_d    = dst_base;
                    len_d    = len;
                    op_d     = op_sel;
                    k_d      = op_k;
                    rd_idx_d = '0;
                    xfer_d   = '0;
                    state_d  = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_DONE;
                    vpipe_d = '0;
                end else begin
                    rd_idx_d = rd_idx_q + CNT_ONE;
                    if (rd_idx_q == len_q - CNT_ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Stale valids would otherwise leak into the next job after an abort.
                if (abort) begin
                    state_d = ST_DONE;
                    vpipe_d = '0;
                end else if (vpipe_q == '0 && xfer_q == len_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            op_q      <= '0;
            k_q       <= '0;
            rd_idx_q  <= '0;
            vpipe_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            xfer_q    <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            op_q      <= op_d;
            k_q       <= k_d;
            rd_idx_q  <= rd_idx_d;
            vpipe_q   <= vpipe_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            xfer_q    <= xfer_d;
        end
    end

    assign rd_en    = rd_fire;
    assign rd_addr  = src_q + rd_idx_q[ADDR_W-1:0];
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = active;
    assign done     = (state_q == ST_DONE);
    assign xfer_cnt = xfer_q;

endmodule

// File: tb/tb_memxfer_engine.sv
// Runs RD_LAT=1 and RD_LAT=3 engines side by side on identical jobs against a cycle-level job model.
module tb_memxfer_engine;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int NONE  = 1 << 20;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [AW:0]   len = '0;
    logic [1:0]    op_sel = '0;
    logic [DW-1:0] op_k = '0;

    logic [1:0]    rd_en_w, wr_en_w, busy_w, done_w;
    logic [AW-1:0] rd_addr_w [2];
    logic [AW-1:0] wr_addr_w [2];
    logic [DW-1:0] wr_data_w [2];
    logic [AW:0]   xfer_w [2];

    logic [DW-1:0] src_mem [DEPTH];
    logic [DW-1:0] dst_mem [2][DEPTH];
    logic [DW-1:0] ram_l1_q;
    logic [DW-1:0] ram_l3_q [3];

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    // Current job as seen by the model
    int job_valid = 0;
    int j_t0 = 0, j_src = 0, j_dst = 0, j_len = 0, j_op = 0, j_k = 0, j_abort = NONE;
    int prev_cnt [2];
    int obs_done [2];
    int obs_first [2];
    int last_wr [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memxfer_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_dut_l1 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .src_base(src_base), .dst_base(dst_base), .len(len), .op_sel(op_sel), .op_k(op_k),
        .rd_en(rd_en_w[0]), .rd_addr(rd_addr_w[0]), .rd_data(ram_l1_q),
        .wr_en(wr_en_w[0]), .wr_addr(wr_addr_w[0]), .wr_data(wr_data_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .xfer_cnt(xfer_w[0])
    );

    memxfer_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) u_dut_l3 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .src_base(src_base), .dst_base(dst_base), .len(len), .op_sel(op_sel), .op_k(op_k),
        .rd_en(rd_en_w[1]), .rd_addr(rd_addr_w[1]), .rd_data(ram_l3_q[2]),
        .wr_en(wr_en_w[1]), .wr_addr(wr_addr_w[1]), .wr_data(wr_data_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .xfer_cnt(xfer_w[1])
    );

    // Source RAMs with 1- and 3-cycle read latency
    always @(posedge clk) begin
        ram_l1_q    <= rd_en_w[0] ? src_mem[rd_addr_w[0]] : '0;
        ram_l3_q[0] <= rd_en_w[1] ? src_mem[rd_addr_w[1]] : '0;
        ram_l3_q[1] <= ram_l3_q[0];
        ram_l3_q[2] <= ram_l3_q[1];
    end

    function automatic int xf(input int op, input int k, input int d);
        case (op)
            0: return d;
`ifdef MEMXFER_SAT_EN
            1: return (d + k > 255) ? 255 : d + k;
            3: return (d < k) ? 0 : d - k;
`else
            1: return (d + k) % 256;
            3: return (d - k + 256) % 256;
`endif
            default: return d ^ k;
        endcase
    endfunction

    function automatic int exp_done(input int lat);
        if (j_len == 0) return 1;
        if (j_abort >= 1 && j_abort <= j_len + lat + 1) return j_abort + 1;
        return j_len + lat + 2;
    endfunction

    // Writes occupy cycles lat+2 .. len+lat+1, cut short by an abort.
    function automatic int exp_cnt(input int lat, input int t);
        int last;
        last = t;
        if (last > j_len + lat + 1) last = j_len + lat + 1;
        if (last > exp_done(lat) - 1) last = exp_done(lat) - 1;
        return (last >= lat + 2) ? last - (lat + 2) + 1 : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_inst(input int i);
        int lat, t, d, j;
        bit e_rd, e_wr;
        string p;
        lat = (i == 0) ? 1 : 3;
        p = (i == 0) ? "l1" : "l3";
        t = cyc - j_t0;
        if (!reset_n) begin
            chk({p, ".rst.rd_en"}, int'(rd_en_w[i]), 0);
            chk({p, ".rst.rd_addr"}, int'(rd_addr_w[i]), 0);
            chk({p, ".rst.wr_en"}, int'(wr_en_w[i]), 0);
            chk({p, ".rst.wr_addr"}, int'(wr_addr_w[i]), 0);
            chk({p, ".rst.wr_data"}, int'(wr_data_w[i]), 0);
            chk({p, ".rst.busy"}, int'(busy_w[i]), 0);
            chk({p, ".rst.done"}, int'(done_w[i]), 0);
            chk({p, ".rst.xfer_cnt"}, int'(xfer_w[i]), 0);
        end else if (job_valid == 0 || t < 1) begin
            chk({p, ".idle.busy"}, int'(busy_w[i]), 0);
            chk({p, ".idle.done"}, int'(done_w[i]), 0);
            chk({p, ".idle.rd_en"}, int'(rd_en_w[i]), 0);
            chk({p, ".idle.wr_en"}, int'(wr_en_w[i]), 0);
            chk({p, ".idle.xfer_cnt"}, int'(xfer_w[i]), prev_cnt[i]);
        end else begin
            d = exp_done(lat);
            e_rd = (t <= j_len) && (t < d);
            e_wr = (t >= lat + 2) && (t <= j_len + lat + 1) && (t < d);
            chk({p, ".busy"}, int'(busy_w[i]), int'(t < d));
            chk({p, ".done"}, int'(done_w[i]), int'(t == d));
            chk({p, ".rd_en"}, int'(rd_en_w[i]), int'(e_rd));
            chk({p, ".wr_en"}, int'(wr_en_w[i]), int'(e_wr));
            chk({p, ".xfer_cnt"}, int'(xfer_w[i]), exp_cnt(lat, t));
            if (e_rd && rd_en_w[i])
                chk({p, ".rd_addr"}, int'(rd_addr_w[i]), (j_src + t - 1) % DEPTH);
            if (e_wr && wr_en_w[i]) begin
                j = t - lat - 2;
                chk({p, ".wr_addr"}, int'(wr_addr_w[i]), (j_dst + j) % DEPTH);
                chk({p, ".wr_data"}, int'(wr_data_w[i]),
                    xf(j_op, j_k, int'(src_mem[(j_src + j) % DEPTH])));
            end
            if (wr_en_w[i]) begin
                dst_mem[i][wr_addr_w[i]] = wr_data_w[i];
                last_wr[i] = int'(wr_data_w[i]);
                if (obs_first[i] < 0) obs_first[i] = t;
            end
            if (done_w[i] && obs_done[i] < 0) obs_done[i] = t;
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) check_inst(i);
    end

    // Start sampled at t=0; ab/ms/rs are cycle offsets for abort, mid-job start and reset.
    task automatic run_job(input int s, input int d, input int n, input int op, input int k,
                           input int ab, input int ms, input int rs);
        bit [31:0] r;
        @(posedge clk); #1;
        if (job_valid != 0) begin
            prev_cnt[0] = exp_cnt(1, NONE);
            prev_cnt[1] = exp_cnt(3, NONE);
        end
        j_src = s; j_dst = d; j_len = n; j_op = op; j_k = k; j_abort = ab;
        j_t0 = cyc; job_valid = 1;
        for (int i = 0; i < 2; i++) begin
            obs_done[i] = -1;
            obs_first[i] = -1;
        end
        src_base = s[AW-1:0]; dst_base = d[AW-1:0]; len = n[AW:0];
        op_sel = op[1:0]; op_k = k[DW-1:0]; start = 1'b1;
        for (int t = 1; t <= n + 8; t++) begin
            @(posedge clk); #1;
            start = (t == ms);
            abort = (t == ab);
            if (t == rs) begin
                reset_n = 1'b0;
                job_valid = 0;
                prev_cnt[0] = 0;
                prev_cnt[1] = 0;
            end
            if (t == rs + 2) reset_n = 1'b1;
            r = $urandom; src_base = r[AW-1:0]; dst_base = r[2*AW-1:AW];
            r = $urandom; len = r[AW:0]; op_sel = r[21:20]; op_k = r[31:24];
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int nerr;
        bit [31:0] r;
        int n, ab;
        prev_cnt[0] = 0; prev_cnt[1] = 0;
        for (int i = 0; i < DEPTH; i++) src_mem[i] = DW'(i % 256);
        for (int i = 0; i < 2; i++) begin
            obs_done[i] = -1; obs_first[i] = -1; last_wr[i] = -1;
            for (int a = 0; a < DEPTH; a++) dst_mem[i][a] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Full-memory add-42 copy
        run_job(0, 0, 1024, 1, 42, NONE, NONE, NONE);
        chk("copy.l1.done_cycle", obs_done[0], 1027);
        chk("copy.l3.done_cycle", obs_done[1], 1029);
        chk("copy.l1.xfer_cnt", int'(xfer_w[0]), 1024);
        nerr = 0;
        for (int i = 0; i < DEPTH; i++)
            if (int'(dst_mem[0][i]) != (i + 42) % 256) nerr++;
        chk("copy.l1.dst_words_wrong", nerr, 0);

        // Address wrap with xor 0xFF
        run_job(1020, 5, 8, 2, 255, NONE, NONE, NONE);
        chk("wrap.dst5", int'(dst_mem[0][5]), 3);
        chk("wrap.dst12", int'(dst_mem[0][12]), 252);
        chk("wrap.xfer_cnt", int'(xfer_w[0]), 8);

        // Read-latency sweep
        run_job(100, 200, 4, 0, 0, NONE, NONE, NONE);
        chk("lat.l3.first_wr", obs_first[1], 5);
        chk("lat.l3.done_cycle", obs_done[1], 9);
        chk("lat.l1.first_wr", obs_first[0], 3);
        chk("lat.l3.dst203", int'(dst_mem[1][203]), 103);

        // Zero length, then a job with start pulsed while busy
        run_job(7, 9, 0, 1, 1, NONE, NONE, NONE);
        chk("zero.l1.done_cycle", obs_done[0], 1);
        chk("zero.l3.done_cycle", obs_done[1], 1);
        chk("zero.xfer_cnt", int'(xfer_w[0]), 0);
        run_job(10, 600, 30, 1, 7, NONE, 5, NONE);
        chk("busystart.l1.xfer_cnt", int'(xfer_w[0]), 30);
        chk("busystart.l3.done_cycle", obs_done[1], 35);

        // Abort in cycle 20
        run_job(0, 0, 100, 0, 0, 20, NONE, NONE);
        chk("abort.l1.done_cycle", obs_done[0], 21);
        chk("abort.l1.xfer_cnt", int'(xfer_w[0]), 18);
        chk("abort.l3.xfer_cnt", int'(xfer_w[1]), 16);

        // Saturating versus wrapping arithmetic
        src_mem[0] = 8'd100;
        src_mem[1] = 8'd3;
`ifdef MEMXFER_SAT_EN
        chk("model.add_sat", xf(1, 200, 100), 255);
        run_job(0, 0, 1, 1, 200, NONE, NONE, NONE);
        chk("sat.add", last_wr[0], 255);
        run_job(1, 0, 1, 3, 10, NONE, NONE, NONE);
        chk("sat.sub", last_wr[1], 0);
`else
        chk("model.add_wrap", xf(1, 200, 100), 44);
        run_job(0, 0, 1, 1, 200, NONE, NONE, NONE);
        chk("wrap.add", last_wr[0], 44);
        run_job(1, 0, 1, 3, 10, NONE, NONE, NONE);
        chk("wrap.sub", last_wr[1], 249);
`endif

        // Reset mid-job
        run_job(0, 0, 50, 1, 1, NONE, NONE, 10);
        chk("rst.no_done", obs_done[0], -1);
        chk("rst.xfer_cnt", int'(xfer_w[0]), 0);

        // Random jobs over random source data
        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom;
            src_mem[i] = r[DW-1:0];
        end
        for (int q = 0; q < 12; q++) begin
            n  = int'($urandom_range(40, 0));
            ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(n + 4, 1)) : NONE;
            r  = $urandom;
            run_job(int'(r[9:0]), int'(r[19:10]), n, int'(r[21:20]), int'(r[31:24]),
                    ab, NONE, NONE);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
